// File: rtl/reset_sequencer.sv
// Board-level reset controller: conditions the button and lock inputs, then
// holds every domain in reset and releases them one by one in a fixed order.
module reset_sequencer #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGGER_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  input  logic                locked,
  input  logic                sw_req,
  output logic [CHANNELS-1:0] chan_rst,
  output logic                rst_done,
  output logic [1:0]          rst_cause
);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_LOCK = 2'b11
  } cause_t;

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int IDX_W  = $clog2(CHANNELS + 1);

  localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]    STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] CHAN_ALL  = '1;

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   btn_s;
  logic                   lock_s;
  logic                   btn_deb;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   trig;

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CHANNELS-1:0]    chan_q, chan_d;
  logic                   done_q, done_d;
  cause_t                 cause_q, cause_d;

  // NOTE: the synchroniser flops are cleared by rst like any other state, so
  // lock_s reads "unlocked" until the chain has refilled after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync  <= '0;
      lock_sync <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_in};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  // Debouncer: follow btn_s only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_deb <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_s != btn_deb) begin
      if (deb_cnt == DEB_LAST) begin
        btn_deb <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign trig = btn_deb | sw_req | ~lock_s;

  // NOTE: all sequential state is updated with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      chan_q  <= CHAN_ALL;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // NOTE: every next-state variable is given its hold value first so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    done_d  = done_q;
    cause_d = cause_q;

    unique case (state_q)
      ST_ASSERT: begin
        chan_d = CHAN_ALL;
        done_d = 1'b0;
        if (trig) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          stg_d  = '0;
          idx_d  = IDX_W'(1);
          chan_d = CHAN_ALL << 1;
          if (CHANNELS == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        // Channels below idx are already released, so a left shift frees idx.
        if (stg_q == STG_LAST) begin
          stg_d  = '0;
          chan_d = chan_q << 1;
          idx_d  = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      ST_RUN: begin
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    // A trigger outside ASSERT restarts the sequence and records its cause.
    if (trig && (state_q != ST_ASSERT)) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      stg_d   = '0;
      idx_d   = '0;
      chan_d  = CHAN_ALL;
      done_d  = 1'b0;
      if (!lock_s)      cause_d = CAUSE_LOCK;
      else if (btn_deb) cause_d = CAUSE_BTN;
      else              cause_d = CAUSE_SW;
    end
  end

  assign chan_rst  = chan_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three parameter sets share one stimulus stream,
// each checked every cycle against a release-schedule model, plus fixed checks.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic locked = 1'b1;
  logic sw_req = 1'b0;
  bit   cmp_en = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C  = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    localparam int S  = (g == 2) ? 3 : 2;
    localparam int D  = (g == 2) ? 2 : 4;
    localparam int H  = (g == 0) ? 8 : (g == 1) ? 1 : 3;
    localparam int ST = (g == 2) ? 1 : 4;

    logic [C-1:0] chan_rst;
    logic         rst_done;
    logic [1:0]   rst_cause;

    reset_sequencer #(
      .CHANNELS(C), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES(H), .STAGGER_CYCLES(ST)
    ) u_dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .locked(locked), .sw_req(sw_req),
      .chan_rst(chan_rst), .rst_done(rst_done), .rst_cause(rst_cause)
    );

    // Model: q counts consecutive trigger-free edges; channel k is released
    // once q reaches H + k*ST. Synchronisers are plain S-deep delay lines.
    int       q = 0;
    int       run = 0;
    bit       deb = 1'b0;
    bit [1:0] cause = 2'b00;
    bit       bq[$];
    bit       lq[$];

    initial forever begin
      @(posedge clk);
      if (rst) begin
        q = 0; run = 0; deb = 1'b0; cause = 2'b00;
        bq.delete(); lq.delete();
        repeat (S) begin bq.push_back(1'b0); lq.push_back(1'b0); end
      end else if (bq.size() == S) begin
        bit bs, ls, trig;
        bs = bq.pop_front(); bq.push_back(btn_in);
        ls = lq.pop_front(); lq.push_back(locked);
        trig = deb | sw_req | !ls;
        if (trig) begin
          if (q >= H) cause = !ls ? 2'b11 : deb ? 2'b01 : 2'b10;
          q = 0;
        end else if (q < 1000000) begin
          q++;
        end
        if (bs != deb) begin
          run++;
          if (run == D) begin deb = bs; run = 0; end
        end else begin
          run = 0;
        end
      end
    end

    always @(negedge clk) begin
      if (cmp_en) begin
        logic [C-1:0] ec;
        logic         ed;
        for (int k = 0; k < C; k++) ec[k] = !(q >= H + k * ST);
        ed = (q >= H + (C - 1) * ST);
        n_cmp++;
        if (chan_rst !== ec || rst_done !== ed || rst_cause !== cause) begin
          n_fail++;
          $display("FAIL model_cmp[%0d] t=%0t: got chan=%0h done=%0b cause=%0d, expected chan=%0h done=%0b cause=%0d",
                   g, $time, chan_rst, rst_done, rst_cause, ec, ed, cause);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bounded wait for the default instance to show a given channel pattern.
  task automatic wait_chan0(input logic [3:0] pat, input int budget, input string name);
    int n;
    n = 0;
    while (g_dut[0].chan_rst !== pat && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(g_dut[0].chan_rst), 32'(pat));
  endtask

  initial begin
    bit dropped;
    int hold_btn;

    // Power-on: three cycles of rst, locked steady.
    repeat (3) tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 2)  check("g1_edge2_chan",  32'(g_dut[1].chan_rst), 32'h1);
      if (e == 3)  check("g1_edge3_done",  32'(g_dut[1].rst_done), 32'h1);
      if (e == 6)  check("g2_edge6_chan",  32'(g_dut[2].chan_rst), 32'hFE);
      if (e == 9)  check("por_edge9",      32'(g_dut[0].chan_rst), 32'hF);
      if (e == 10) check("por_edge10",     32'(g_dut[0].chan_rst), 32'hE);
      if (e == 12) check("g2_edge12_done", 32'(g_dut[2].rst_done), 32'h0);
      if (e == 13) check("g2_edge13_done", 32'(g_dut[2].rst_done), 32'h1);
      if (e == 14) check("por_edge14",     32'(g_dut[0].chan_rst), 32'hC);
      if (e == 18) check("por_edge18",     32'(g_dut[0].chan_rst), 32'h8);
      if (e == 21) check("por_edge21_done", 32'(g_dut[0].rst_done), 32'h0);
      if (e == 22) begin
        check("por_edge22",      32'(g_dut[0].chan_rst),  32'h0);
        check("por_edge22_done", 32'(g_dut[0].rst_done),  32'h1);
        check("por_cause",       32'(g_dut[0].rst_cause), 32'h0);
      end
    end

    // Software reset in RUN.
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check("sw_chan",  32'(g_dut[0].chan_rst),  32'hF);
    check("sw_cause", 32'(g_dut[0].rst_cause), 32'h2);
    repeat (7) tick();
    check("sw_edge7",  32'(g_dut[0].chan_rst), 32'hF);
    tick();
    check("sw_edge8",  32'(g_dut[0].chan_rst), 32'hE);
    repeat (20) tick();
    check("run_before_bounce", 32'(g_dut[0].rst_done), 32'h1);

    // Bouncing button: runs of two never survive a four-cycle debounce.
    dropped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      btn_in = ((i / 2) % 2) != 0;
      tick();
      if (g_dut[0].rst_done !== 1'b1) dropped = 1'b1;
    end
    btn_in = 1'b0;
    repeat (4) tick();
    if (g_dut[0].rst_done !== 1'b1) dropped = 1'b1;
    check("bounce_no_reset", 32'(dropped), 32'h0);

    // Held button: asserts 6 edges after the first high sample.
    btn_in = 1'b1;
    repeat (6) tick();
    check("btn_edge5_chan", 32'(g_dut[0].chan_rst), 32'h0);
    tick();
    check("btn_edge6_chan", 32'(g_dut[0].chan_rst),  32'hF);
    check("btn_cause",      32'(g_dut[0].rst_cause), 32'h1);
    repeat (3) tick();
    btn_in = 1'b0;
    repeat (40) tick();
    check("run_after_button", 32'(g_dut[0].rst_done), 32'h1);

    // Lock loss while the sequence is part-way through releasing.
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    wait_chan0(4'hC, 40, "reach_1100");
    locked = 1'b0;
    tick();
    tick();
    check("lock_edge1_chan", 32'(g_dut[0].chan_rst), 32'hC);
    tick();
    check("lock_edge2_chan", 32'(g_dut[0].chan_rst),  32'hF);
    check("lock_cause",      32'(g_dut[0].rst_cause), 32'h3);
    repeat (3) tick();
    locked = 1'b1;
    repeat (9) tick();
    check("relock_edge9",  32'(g_dut[0].chan_rst), 32'hF);
    tick();
    check("relock_edge10", 32'(g_dut[0].chan_rst), 32'hE);
    repeat (20) tick();
    check("run_before_simul", 32'(g_dut[0].rst_done), 32'h1);

    // Software request on the same edge the debounced button triggers.
    btn_in = 1'b1;
    repeat (6) tick();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    btn_in = 1'b0;
    check("simul_chan",  32'(g_dut[0].chan_rst),  32'hF);
    check("simul_cause", 32'(g_dut[0].rst_cause), 32'h1);

    // Sequencer reset part-way through the release sequence.
    wait_chan0(4'hC, 60, "reach_1100_again");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_chan",  32'(g_dut[0].chan_rst),  32'hF);
    check("midrst_done",  32'(g_dut[0].rst_done),  32'h0);
    check("midrst_cause", 32'(g_dut[0].rst_cause), 32'h0);

    // Randomised traffic against the models.
    hold_btn = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_btn == 0) begin
        btn_in   = ($urandom_range(0, 3) == 0);
        hold_btn = $urandom_range(1, 14);
      end else begin
        hold_btn--;
      end
      if (locked) locked = !($urandom_range(0, 99) < 2);
      else        locked = ($urandom_range(0, 99) < 15);
      sw_req = ($urandom_range(0, 39) == 0);
      rst    = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    sw_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised board-level reset controller placed between the raw board inputs (`reset_btn`, clock-source lock) and the SoC, replacing the single-output reset synchroniser. It synchronises and debounces the reset button and accepts a software reset request. It monitors clock-source lock and releases a configurable number of per-domain resets in a fixed staggered order, reporting completion and the cause of the last reset.

## Interface
Parameters:
- `CHANNELS`, 4: number of reset domains; legal range ≥1.
- `SYNC_STAGES`, 2: flip-flop stages on `btn_in` and `locked`; legal range ≥2.
- `DEBOUNCE_CYCLES`, 4: stable cycles required before the debounced button changes; legal range ≥1.
- `HOLD_CYCLES`, 8: qualifying cycles in ASSERT before the first release; legal range ≥1.
- `STAGGER_CYCLES`, 4: cycles between consecutive channel releases; legal range ≥1.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: reset. Synchronous, active-high; the power-on reset of the sequencer itself.
- `btn_in` in 1: raw reset button, asynchronous, active-high, may bounce.
- `locked` in 1: clock-source lock, asynchronous, high = locked.
- `sw_req` in 1: software reset request, synchronous to `clk`, single-cycle pulse.
- `chan_rst` out CHANNELS: per-domain reset, active-high. Bit 0 is released first.
- `rst_done` out 1: high while all channels are released.
- `rst_cause` out 2: cause of the last reset. 00 = power-on, 01 = button, 10 = software, 11 = lock loss.

## Operation
- Input conditioning:
  - `btn_in` and `locked` each pass through a SYNC_STAGES-deep synchroniser chain, giving `btn_s` and `lock_s`.
  - Debouncer: `btn_deb` takes the value of `btn_s` once `btn_s` has differed from `btn_deb` for DEBOUNCE_CYCLES consecutive cycles. Any cycle of agreement clears the debounce counter.
- Trigger: `trig = btn_deb | sw_req | ~lock_s`.
- Cause priority for simultaneous triggers: lock loss > button > software.
- State machine states: ASSERT, RELEASE, RUN.
- ASSERT:
  - All `chan_rst` = 1 and `rst_done` = 0.
  - The hold counter increments on each cycle with `trig` = 0 and clears on any cycle with `trig` = 1.
  - When the counter reaches HOLD_CYCLES−1 and `trig` = 0: clear `chan_rst[0]`, move to RELEASE with channel index 1 and stagger counter 0.
- RELEASE:
  - The stagger counter increments each cycle. At STAGGER_CYCLES−1 it clears `chan_rst[idx]`, increments `idx` and resets to 0.
  - Releasing channel CHANNELS−1 moves the FSM to RUN and sets `rst_done` = 1 on the same edge.
  - With CHANNELS = 1, ASSERT goes directly to RUN.
- RUN: outputs are held.
- `trig` = 1 in RELEASE or RUN:
  - Next edge: all `chan_rst` = 1, `rst_done` = 0, state ASSERT, counters cleared, `rst_cause` updated by priority.
  - `trig` in ASSERT does not change `rst_cause`. A trigger seen during RELEASE does change it.
- `rst_cause` holds its value until the next trigger.
- Counters are sized with $clog2 of their maximum value plus 1; none wrap in legal operation.
- `rst` = 1 at any time, including mid-sequence:
  - Next edge: state ASSERT, `chan_rst` = all ones, `rst_done` = 0, `rst_cause` = 00.
  - Synchronisers, `btn_deb`, and all counters return to 0.

## Timing
- Reset values:
  - `chan_rst` = {CHANNELS{1}}, `rst_done` = 0, `rst_cause` = 00.
  - Internally, state = ASSERT and `btn_deb` = 0.
  - Synchroniser flops reset to 0, so `lock_s` = 0 until the chain fills; this extends ASSERT by SYNC_STAGES cycles.
- Edge numbering: edge 1 is the first edge with `rst` = 0.
- Release schedule with `locked` steadily high, button idle and no `sw_req`:
  - The qualifying window starts at edge SYNC_STAGES+1.
  - `chan_rst[k]` falls after edge SYNC_STAGES + HOLD_CYCLES + k·STAGGER_CYCLES.
  - `rst_done` rises with the last channel.
- `sw_req` sampled high at edge t in RUN: `chan_rst` is all ones after edge t.
- Button: `btn_in` first sampled high and held stable at edge t.
  - `btn_deb` rises after edge t + SYNC_STAGES + DEBOUNCE_CYCLES − 1.
  - `chan_rst` asserts after edge t + SYNC_STAGES + DEBOUNCE_CYCLES.
- Lock loss: `locked` first sampled low at edge t. `chan_rst` asserts after edge t + SYNC_STAGES.
- Holding the button, or staying unlocked, keeps ASSERT indefinitely. Release resumes HOLD_CYCLES cycles after `trig` falls.

## Test plan
- Power-on (defaults):
  - Stimulus: `rst` high for 3 cycles then low; `locked` = 1.
  - Response: `chan_rst` = 1111 until edge 10, then 1110 (edge 10), 1100 (edge 14), 1000 (edge 18), 0000 (edge 22).
  - `rst_done` = 1 from edge 22; `rst_cause` = 00.
- Software reset in RUN: one-cycle `sw_req` pulse → `chan_rst` = 1111 at the next edge, `rst_cause` = 10. Release schedule repeats with ch0 falling 8 edges later.
- Bounce rejection:
  - Stimulus: `btn_in` toggles every 2 cycles for 40 cycles, then low.
  - Response: no reset; `rst_done` stays 1.
  - Then hold `btn_in` high for 10 cycles → `chan_rst` asserts 6 edges after the first high sample, `rst_cause` = 01.
- Lock loss mid-RELEASE:
  - Stimulus: `locked` dropped when `chan_rst` = 1100.
  - Response: `chan_rst` = 1111 two edges later, `rst_cause` = 11.
  - Relock: release restarts after HOLD_CYCLES + SYNC_STAGES edges.
- Simultaneous triggers: `sw_req` and a debounced button in the same cycle → `rst_cause` = 01. `rst` asserted at edge 15 of the sequence → all outputs reset next edge, `rst_cause` = 00.
- Parameter sweep: CHANNELS = 1 and 8; STAGGER_CYCLES = 1; HOLD_CYCLES = 1. Release edges must match the formula exactly.
